// File: rtl/io_arbiter.sv
// PDP-8/e peripheral concentrator: IOT decode, irq synchroniser, round-robin data-break arbiter.
// IOT result 1 clk after strobe, irq 3 clk after level change; no backpressure, grant held until brk_done.
module io_arbiter #(
    parameter int NCHAN   = 4,
    parameter int BRK_MAX = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [11:0]           instruction,
    input  logic                  iot_strobe,
    input  logic [6*NCHAN-1:0]    dev_code,
    input  logic [12*NCHAN-1:0]   dev_bus,
    input  logic [NCHAN-1:0]      dev_skip,
    input  logic [NCHAN-1:0]      dev_irq,
    input  logic [NCHAN-1:0]      dev_brk_req,
    input  logic                  cycle_boundary,
    input  logic                  brk_done,
    output logic [11:0]           in_bus,
    output logic                  skip,
    output logic [NCHAN-1:0]      dev_sel,
    output logic                  irq,
    output logic [NCHAN-1:0]      brk_grant,
    output logic                  break_in_prog,
    output logic                  collision
);

    localparam int IW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    typedef enum logic {IDLE, BREAK} state_t;

    logic             is_iot;
    logic [NCHAN-1:0] match;
    logic [IW-1:0]    win;
    logic             multi;

    logic [NCHAN-1:0] irq_s1;
    logic [NCHAN-1:0] irq_s2;

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    gnt_idx;
    logic [IW-1:0]    gnt_next;
    logic [3:0]       burst;
    logic             found;
    logic [IW-1:0]    pick;

    assign is_iot = iot_strobe && (instruction[11:9] == 3'b110);

    // Descending scan so the lowest matching channel is the one left in win.
    always_comb begin
        match = '0;
        win   = '0;
        for (int k = NCHAN - 1; k >= 0; k--) begin
            if (dev_code[6*k +: 6] == instruction[8:3]) begin
                match[k] = 1'b1;
                win      = IW'(k);
            end
        end
    end

    assign multi = |(match & (match - NCHAN'(1)));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dev_sel   <= '0;
            in_bus    <= '0;
            skip      <= 1'b0;
            collision <= 1'b0;
        end else if (iot_strobe) begin
            if (is_iot && (|match)) begin
                dev_sel <= NCHAN'(1) << win;
                in_bus  <= dev_bus[12*win +: 12];
                skip    <= dev_skip[win];
                if (multi)
                    collision <= 1'b1;
            end else begin
                dev_sel <= '0;
                in_bus  <= '0;
                skip    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_s1 <= '0;
            irq_s2 <= '0;
            irq    <= 1'b0;
        end else begin
            irq_s1 <= dev_irq;
            irq_s2 <= irq_s1;
            irq    <= |irq_s2;
        end
    end

    // Rotating search starting at ptr, wrapping past the last channel.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        for (int i = 0; i < NCHAN; i++) begin
            int          j;
            logic [IW-1:0] jj;
            j = int'(ptr) + i;
            if (j >= NCHAN)
                j = j - NCHAN;
            jj = IW'(j);
            if (!found && dev_brk_req[jj]) begin
                found = 1'b1;
                pick  = jj;
            end
        end
    end

    assign gnt_next = (gnt_idx == IW'(NCHAN - 1)) ? '0 : gnt_idx + IW'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            ptr           <= '0;
            gnt_idx       <= '0;
            burst         <= '0;
            brk_grant     <= '0;
            break_in_prog <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cycle_boundary && found) begin
                        state         <= BREAK;
                        gnt_idx       <= pick;
                        brk_grant     <= NCHAN'(1) << pick;
                        break_in_prog <= 1'b1;
                        burst         <= 4'd1;
                    end
                end
                BREAK: begin
                    if (brk_done) begin
                        if (dev_brk_req[gnt_idx] && (burst < 4'(BRK_MAX))) begin
                            burst <= burst + 4'd1;
                        end else begin
                            state         <= IDLE;
                            brk_grant     <= '0;
                            break_in_prog <= 1'b0;
                            ptr           <= gnt_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_arbiter.sv
// Directed bench for io_arbiter: IOT decode/collision, irq latency, round-robin, burst limit, reset mid-break.
module tb_io_arbiter;

    logic        clk;
    logic        resetn;
    logic [11:0] instruction;
    logic        iot_strobe;
    logic [23:0] dev_code;
    logic [47:0] dev_bus;
    logic [3:0]  dev_skip;
    logic [3:0]  dev_irq;
    logic [3:0]  dev_brk_req;
    logic        cycle_boundary;
    logic        brk_done;

    logic [11:0] in_bus0, in_bus1;
    logic        skip0, skip1;
    logic [3:0]  sel0, sel1;
    logic        irq0, irq1;
    logic [3:0]  gnt0, gnt1;
    logic        bip0, bip1;
    logic        coll0, coll1;

    int n_checks = 0;
    int n_fail   = 0;

    io_arbiter #(.NCHAN(4), .BRK_MAX(4)) u_dut (
        .clk(clk), .resetn(resetn), .instruction(instruction), .iot_strobe(iot_strobe),
        .dev_code(dev_code), .dev_bus(dev_bus), .dev_skip(dev_skip), .dev_irq(dev_irq),
        .dev_brk_req(dev_brk_req), .cycle_boundary(cycle_boundary), .brk_done(brk_done),
        .in_bus(in_bus0), .skip(skip0), .dev_sel(sel0), .irq(irq0),
        .brk_grant(gnt0), .break_in_prog(bip0), .collision(coll0)
    );

    io_arbiter #(.NCHAN(4), .BRK_MAX(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .instruction(instruction), .iot_strobe(iot_strobe),
        .dev_code(dev_code), .dev_bus(dev_bus), .dev_skip(dev_skip), .dev_irq(dev_irq),
        .dev_brk_req(dev_brk_req), .cycle_boundary(cycle_boundary), .brk_done(brk_done),
        .in_bus(in_bus1), .skip(skip1), .dev_sel(sel1), .irq(irq1),
        .brk_grant(gnt1), .break_in_prog(bip1), .collision(coll1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [11:0] instr);
        instruction = instr;
        iot_strobe  = 1'b1;
        tick();
        iot_strobe  = 1'b0;
    endtask

    task automatic pulse_done;
        brk_done = 1'b1;
        tick();
        brk_done = 1'b0;
    endtask

    task automatic wait_grant(input int which, input int budget);
        bit got;
        got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            tick();
            got = (which == 0) ? (gnt0 != 4'b0) : (gnt1 != 4'b0);
        end
        check($sformatf("grant_wait_dut%0d", which), 32'(got), 32'd1);
    endtask

    initial begin
        resetn         = 1'b0;
        instruction    = '0;
        iot_strobe     = 1'b0;
        dev_code       = '0;
        dev_bus        = '0;
        dev_skip       = '0;
        dev_irq        = '0;
        dev_brk_req    = '0;
        cycle_boundary = 1'b0;
        brk_done       = 1'b0;

        #3;
        check("rst_in_bus", 32'(in_bus0), 32'd0);
        check("rst_skip", 32'(skip0), 32'd0);
        check("rst_dev_sel", 32'(sel0), 32'd0);
        check("rst_irq", 32'(irq0), 32'd0);
        check("rst_grant", 32'(gnt0), 32'd0);
        check("rst_bip", 32'(bip0), 32'd0);
        check("rst_collision", 32'(coll0), 32'd0);
        check("rst_grant_dut1", 32'(gnt1), 32'd0);
        tick();
        tick();
        resetn = 1'b1;

        // IOT decode, hold, non-IOT opcode and no-match cases
        dev_code = {6'o77, 6'o03, 6'o11, 6'o22};
        dev_bus  = {12'o7777, 12'o1234, 12'o0002, 12'o0001};
        dev_skip = 4'b0100;
        strobe(12'o6031);
        check("iot_in_bus", 32'(in_bus0), 32'o1234);
        check("iot_skip", 32'(skip0), 32'd1);
        check("iot_dev_sel", 32'(sel0), 32'b0100);
        check("iot_collision", 32'(coll0), 32'd0);
        dev_bus[24 +: 12] = 12'o5555;
        dev_skip = 4'b0000;
        tick();
        tick();
        check("iot_hold_in_bus", 32'(in_bus0), 32'o1234);
        check("iot_hold_skip", 32'(skip0), 32'd1);
        strobe(12'o7031);
        check("non_iot_dev_sel", 32'(sel0), 32'd0);
        check("non_iot_in_bus", 32'(in_bus0), 32'd0);
        strobe(12'o6031);
        check("iot2_in_bus", 32'(in_bus0), 32'o5555);
        check("iot2_skip", 32'(skip0), 32'd0);
        strobe(12'o6551);
        check("nomatch_dev_sel", 32'(sel0), 32'd0);
        check("nomatch_in_bus", 32'(in_bus0), 32'd0);

        // Collision: ch0 and ch3 share code 40
        dev_code = {6'o40, 6'o03, 6'o11, 6'o40};
        dev_bus[0 +: 12] = 12'o4321;
        dev_skip = 4'b0001;
        strobe(12'o6401);
        check("coll_dev_sel", 32'(sel0), 32'b0001);
        check("coll_in_bus", 32'(in_bus0), 32'o4321);
        check("coll_skip", 32'(skip0), 32'd1);
        check("coll_set", 32'(coll0), 32'd1);
        strobe(12'o6031);
        check("coll_next_sel", 32'(sel0), 32'b0100);
        check("coll_sticky", 32'(coll0), 32'd1);
        resetn = 1'b0;
        #1;
        check("coll_reset", 32'(coll0), 32'd0);
        check("coll_reset_sel", 32'(sel0), 32'd0);
        tick();
        resetn = 1'b1;
        dev_code = {6'o40, 6'o03, 6'o11, 6'o22};

        // Interrupt synchroniser latency
        dev_irq = 4'b0010;
        tick();
        tick();
        check("irq_rise_early", 32'(irq0), 32'd0);
        tick();
        check("irq_rise", 32'(irq0), 32'd1);
        repeat (7) tick();
        dev_irq = 4'b0000;
        tick();
        tick();
        check("irq_fall_early", 32'(irq0), 32'd1);
        tick();
        check("irq_fall", 32'(irq0), 32'd0);

        // Round-robin with BRK_MAX=1 on u_dut1
        dev_brk_req    = 4'b0101;
        cycle_boundary = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_grant(1, 20);
            check($sformatf("rr_grant%0d", g), 32'(gnt1), (g % 2 == 1) ? 32'b0100 : 32'b0001);
            check($sformatf("rr_bip%0d", g), 32'(bip1), 32'd1);
            repeat (3) tick();
            pulse_done();
            check($sformatf("rr_drop%0d", g), 32'(gnt1), 32'd0);
            check($sformatf("rr_drop_bip%0d", g), 32'(bip1), 32'd0);
        end
        dev_brk_req = 4'b0000;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;

        // brk_done in IDLE ignored, then burst limit with BRK_MAX=4
        pulse_done();
        check("done_in_idle", 32'(gnt0), 32'd0);
        dev_brk_req = 4'b1010;
        wait_grant(0, 20);
        for (int b = 0; b < 4; b++) begin
            check($sformatf("burst_hold%0d", b), 32'(gnt0), 32'b0010);
            tick();
            pulse_done();
        end
        check("burst_drop", 32'(gnt0), 32'd0);
        wait_grant(0, 20);
        check("burst_next_ch3", 32'(gnt0), 32'b1000);
        dev_brk_req = 4'b0000;
        strobe(12'o6031);
        check("concurrent_iot_sel", 32'(sel0), 32'b0100);
        check("grant_held_no_req", 32'(gnt0), 32'b1000);
        pulse_done();
        check("ch3_drop", 32'(gnt0), 32'd0);
        check("ch3_drop_bip", 32'(bip0), 32'd0);

        // Reset mid-break must clear grant and the pointer
        dev_brk_req = 4'b0001;
        wait_grant(0, 20);
        dev_brk_req = 4'b0000;
        pulse_done();
        check("pre_rst_drop", 32'(gnt0), 32'd0);
        dev_brk_req = 4'b0001;
        wait_grant(0, 20);
        check("pre_rst_grant", 32'(gnt0), 32'b0001);
        dev_brk_req = 4'b0011;
        tick();
        #2;
        resetn = 1'b0;
        #1;
        check("midbrk_rst_grant", 32'(gnt0), 32'd0);
        check("midbrk_rst_bip", 32'(bip0), 32'd0);
        tick();
        resetn = 1'b1;
        wait_grant(0, 20);
        check("ptr_after_reset", 32'(gnt0), 32'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_arbiter.md
Name: io_arbiter

Overview:
- Parametrised N-channel peripheral concentrator for the PDP-8/e core.
- Replaces the fixed per-device irq OR, skip OR and data-bus muxing in the top level with one block.
- Decodes IOT device codes against per-channel configured codes and returns the registered input bus and skip.
- Synchronises and combines device interrupt requests, and arbitrates data-break (DMA) requests round-robin with a per-grant burst limit.

Parameters:
NCHAN, 4, number of peripheral channels (1..8)
BRK_MAX, 4, maximum consecutive break cycles granted to one channel before rotation (1..15)

Ports:
clk  in  1  system clock (100 MHz domain)
resetn  in  1  asynchronous, active-low reset
instruction  in  12  current instruction; IOT when [0:2]=3'b110, device code [3:8]
iot_strobe  in  1  one-cycle pulse while the IOT is executed
dev_code  in  6*NCHAN  static device code per channel; channel k at [6k:6k+5]
dev_bus  in  12*NCHAN  device-to-AC data per channel
dev_skip  in  NCHAN  device skip condition per channel
dev_irq  in  NCHAN  device interrupt level, asynchronous to clk
dev_brk_req  in  NCHAN  data-break request level per channel
cycle_boundary  in  1  state machine can start a break cycle this clock
brk_done  in  1  one-cycle pulse at the end of a break cycle
in_bus  out  12  selected device data, registered
skip  out  1  selected device skip, registered
dev_sel  out  NCHAN  one-hot channel addressed by the last IOT, registered
irq  out  1  combined synchronised interrupt request
brk_grant  out  NCHAN  one-hot break grant
break_in_prog  out  1  a break grant is active
collision  out  1  sticky: an IOT matched more than one channel

Behaviour:
- Reset: all outputs 0. Round-robin pointer 0, burst counter 0, sync flops 0, FSM in IDLE. Reset is asynchronous and is honoured mid-break: grant drops immediately with no brk_done required.
- IOT path:
  - On the clk where iot_strobe=1 and instruction[0:2]=6, compare instruction[3:8] with every dev_code.
  - Lowest-index match wins. Next clk: dev_sel=onehot(winner), in_bus=dev_bus[winner], skip=dev_skip[winner]. Latency 1.
  - Outputs hold until the next strobe.
  - Strobe with no match or non-IOT opcode: dev_sel=0, in_bus=0, skip=0.
  - More than one match: set collision; it clears only on reset.
- Interrupt path:
  - Each dev_irq passes through 2 flops; irq = registered OR of the synchronised bits.
  - Assertion-to-irq latency is 3 clk; deassertion latency is also 3 clk.
  - Not gated by IOT activity.
- Break FSM, states IDLE and BREAK:
  - IDLE: if cycle_boundary=1 and any dev_brk_req, grant the first requesting channel searching ptr, ptr+1, ... mod NCHAN.
    - Next clk: brk_grant onehot, break_in_prog=1, burst=1, state BREAK.
  - BREAK: grant is held regardless of dev_brk_req until brk_done. On brk_done:
    - if the same channel still requests and burst<BRK_MAX, stay in BREAK with the grant unchanged and burst+1;
    - else drop the grant and break_in_prog next clk, set ptr=(granted+1) mod NCHAN, return to IDLE.
  - Requests from other channels during BREAK are only considered after return to IDLE.
  - The minimum gap between grants to different channels is 1 clk in IDLE.
  - brk_done received in IDLE is ignored.
- IOT and break paths are independent. Simultaneous iot_strobe and grant activity are both serviced in the same clk.
- Pointer wrap-around: the search from ptr=NCHAN-1 continues at channel 0.

Test Plan:
- IOT decode: dev_code ch2=6'o03, dev_bus ch2=12'o1234, dev_skip ch2=1; strobe instruction 12'o6031 -> 1 clk later in_bus=12'o1234, skip=1, dev_sel=4'b0100, collision=0.
- Collision: ch0 and ch3 both 6'o40; strobe 12'o6401 -> dev_sel=4'b0001, in_bus=dev_bus[0], collision=1 and held after the next strobe; resetn low -> collision=0.
- Interrupt: pulse dev_irq[1] high at clk 0 -> irq=1 at clk 3; drop at clk 10 -> irq=0 at clk 13.
- Round-robin: BRK_MAX=1, ch0 and ch2 request continuously, cycle_boundary=1, brk_done every 4 clk -> grants alternate ch0, ch2, ch0, ch2; no grant to ch1 or ch3.
- Burst limit: BRK_MAX=4, only ch1 requests with ch3 also requesting -> ch1 receives 4 consecutive brk_done, then ch3 is granted.
- Reset mid-break: ch0 granted, assert resetn=0 before brk_done -> brk_grant=0, break_in_prog=0 asynchronously; after release with ch1 requesting, ch1 is not preferred over ch0 (ptr=0).
